// File: rtl/pow_pkg.sv
// Shared types and widths for the exponentiation-unit feeder.
package pow_pkg;

  localparam int unsigned X_W   = 16;
  localparam int unsigned N_W   = 8;
  localparam int unsigned SEQ_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } feeder_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [N_W-1:0] n;
  } pow_req_t;

endpackage

// File: rtl/req_fifo.sv
// Request FIFO: DEPTH entries of pow_req_t, registered full/empty/count.
// Flags come from the registered count, so a push is never accepted into a
// full FIFO even when a pop happens at the same edge.
module req_fifo
  import pow_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)
(
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           push,
  input  pow_req_t                       wdata,
  input  logic                           pop,
  output pow_req_t                       rdata_c,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  pow_req_t          mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_next;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata_c = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CW'(1);
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/pow_feeder.sv
// Feeder for the square-and-multiply unit: queues requests, issues them one
// at a time with a one-cycle start pulse, and captures results into a
// sequence-tagged one-entry output slot.
module pow_feeder
  import pow_pkg::*;
#(
  parameter int unsigned DEPTH = 4
)
(
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [X_W-1:0]              req_x,
  input  logic [N_W-1:0]              req_n,
  output logic                        pu_start,
  output logic [X_W-1:0]              pu_x,
  output logic [N_W-1:0]              pu_n,
  input  logic                        pu_ready,
  input  logic [X_W-1:0]              pu_out,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [X_W-1:0]              res_data,
  output logic [SEQ_W-1:0]            res_seq,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

  feeder_state_t    state;
  feeder_state_t    state_next;
  pow_req_t         wr_req;
  pow_req_t         head_c;
  logic             full;
  logic             empty;
  logic             push_c;
  logic             issue_c;
  logic             capture_c;
  logic [SEQ_W-1:0] issue_cnt;

  assign wr_req.x  = req_x;
  assign wr_req.n  = req_n;
  assign req_ready = !full;
  assign push_c    = req_valid && !full;

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push    (push_c),
    .wdata   (wr_req),
    .pop     (issue_c),
    .rdata_c (head_c),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus issue/capture strobes; issuing only into a free slot
  // guarantees the capture in WAIT never overwrites an unread result.
  always_comb begin
    state_next = state;
    issue_c    = 1'b0;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && pu_ready && (!res_valid || res_ready)) begin
          issue_c    = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (pu_ready) begin
          capture_c  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers and the one-cycle start pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pu_start <= 1'b0;
      pu_x     <= '0;
      pu_n     <= '0;
    end else begin
      pu_start <= issue_c;
      if (issue_c) begin
        pu_x <= head_c.x;
        pu_n <= head_c.n;
      end
    end
  end

  // Result slot; a capture takes priority over a drain at the same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_seq   <= '0;
      issue_cnt <= '0;
    end else if (capture_c) begin
      res_valid <= 1'b1;
      res_data  <= pu_out;
      res_seq   <= issue_cnt;
      issue_cnt <= issue_cnt + SEQ_W'(1);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
